// File: rtl/io_map_pkg.sv
// Shared MMIO map for the board I/O bridges.
// Holds the LED and switch window bases, the LED address codes, the queued
// LED write entry layout and a helper that applies a popped entry to the LED shadow.
package io_map_pkg;

    localparam logic [31:0] LED_BASE = 32'hFFFF_FC60;
    localparam logic [31:0] SW_BASE  = 32'hFFFF_FC70;

    // LED address codes; the CPU store offset is used directly as the code.
    localparam logic [1:0] LED_ALL = 2'b00;
    localparam logic [1:0] LED_BAD = 2'b01;
    localparam logic [1:0] LED_HI  = 2'b10;
    localparam logic [1:0] LED_LO  = 2'b11;

    localparam int unsigned ENTRY_W = 18;

    typedef struct packed {
        logic [1:0]  code;
        logic [15:0] data;
    } led_entry_t;

    // Next shadow value after the LED stage receives entry e.
    function automatic logic [15:0] shadow_merge(input logic [15:0] cur, input led_entry_t e);
        logic [15:0] nxt;
        nxt = cur;
        case (e.code)
            LED_ALL: nxt       = e.data;
            LED_HI:  nxt[15:8] = e.data[7:0];
            LED_LO:  nxt[7:0]  = e.data[7:0];
            default: nxt       = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read.
// Ports: clk, rst (async, active-high), push/din write side, pop/dout read side,
// full/empty status. Push while full and pop while empty are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FullCount);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until the count says it was written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/led_io_bridge.sv
// CPU MMIO store path to board LED register stage.
// Decodes stores to the LED window, queues them, and drains one entry per cycle
// as a one-cycle led_ctrl pulse; keeps a shadow of the LED state for CPU loads.
// Ports:
//   clk, rst             clock, async active-high reset
//   io_addr/io_wdata     CPU MMIO address and store data
//   io_write/io_read     store / load strobes
//   io_stall             combinational; store to a full queue must be held
//   io_rdata             combinational load data ({16'b0, shadow} on a window load)
//   led_ready            LED stage accepts a write this cycle
//   led_ctrl             registered one-cycle write pulse
//   led_addr/led_wdata   registered LED code and data, held between pulses
//   bad_addr             registered, sticky; store to the reserved offset 01 seen
module led_io_bridge #(
    parameter logic [31:0] LED_BASE = io_map_pkg::LED_BASE,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_write,
    input  logic        io_read,
    output logic        io_stall,
    output logic [31:0] io_rdata,
    input  logic        led_ready,
    output logic        led_ctrl,
    output logic [1:0]  led_addr,
    output logic [31:0] led_wdata,
    output logic        bad_addr
);

    import io_map_pkg::*;

    logic               hit, store_ok, store_bad;
    logic [1:0]         offset;
    logic               fifo_full, fifo_empty, push, pop;
    led_entry_t         push_entry, head_entry;
    logic [ENTRY_W-1:0] head_bits;

    logic               led_ctrl_q, led_ctrl_d;
    logic [1:0]         led_addr_q, led_addr_d;
    logic [15:0]        led_data_q, led_data_d;
    logic               bad_addr_q, bad_addr_d;
    logic [15:0]        shadow_q, shadow_d;

    // Only the low half of store data reaches the LEDs.
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^io_wdata[31:16];

    assign hit       = (io_addr[31:2] == LED_BASE[31:2]);
    assign offset    = io_addr[1:0];
    assign store_ok  = io_write & hit & (offset != LED_BAD);
    assign store_bad = io_write & hit & (offset == LED_BAD);

    assign io_stall  = store_ok & fifo_full;
    assign push      = store_ok & ~fifo_full;
    assign pop       = ~fifo_empty & led_ready;

    assign push_entry = '{code: offset, data: io_wdata[15:0]};
    assign head_entry = led_entry_t'(head_bits);

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        led_ctrl_d = pop;
        led_addr_d = led_addr_q;
        led_data_d = led_data_q;
        shadow_d   = shadow_q;
        bad_addr_d = bad_addr_q | store_bad;
        if (pop) begin
            led_addr_d = head_entry.code;
            led_data_d = head_entry.data;
            shadow_d   = shadow_merge(shadow_q, head_entry);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_ctrl_q <= 1'b0;
            led_addr_q <= LED_ALL;
            led_data_q <= '0;
            bad_addr_q <= 1'b0;
            shadow_q   <= '0;
        end else begin
            led_ctrl_q <= led_ctrl_d;
            led_addr_q <= led_addr_d;
            led_data_q <= led_data_d;
            bad_addr_q <= bad_addr_d;
            shadow_q   <= shadow_d;
        end
    end

    assign led_ctrl  = led_ctrl_q;
    assign led_addr  = led_addr_q;
    assign led_wdata = {16'b0, led_data_q};
    assign bad_addr  = bad_addr_q;
    assign io_rdata  = (io_read && hit) ? {16'b0, shadow_q} : 32'b0;

endmodule
